// File: rtl/tmr_scrub_arbiter_if.sv
// Port bundle between the host/TMR-memory side and the scrub arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface tmr_scrub_arbiter_if #(
  parameter int AW = 6,
  parameter int DW = 8
);
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_mismatch;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata, mem_rdata, mem_mismatch,
    output host_gnt, host_rvalid, host_rdata, mem_we, mem_re, mem_addr, mem_wdata
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata, mem_rdata, mem_mismatch,
    input  host_gnt, host_rvalid, host_rdata, mem_we, mem_re, mem_addr, mem_wdata
  );
endinterface

// File: rtl/tmr_scrub_arbiter.sv
// Single-port arbiter between host traffic and a background scrubber for a
// TMR memory. The scrubber sweeps all addresses with reads and writes the
// voted word back whenever the voter flags a replica mismatch.
module tmr_scrub_arbiter #(
  parameter int AW             = 6,
  parameter int DW             = 8,
  parameter int SCRUB_INTERVAL = 200,
  parameter int STARVE_MAX     = 8,
  parameter int CW             = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scrub_en,
  tmr_scrub_arbiter_if.slave    bus,
  output logic                  scrub_busy,
  output logic                  sweep_done,
  output logic [CW-1:0]         err_count,
  output logic [CW-1:0]         sweep_count
);
  localparam int IW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [IW-1:0] IVL_LAST   = IW'(SCRUB_INTERVAL - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, RD, CHK, WB} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] ivl_cnt;
  logic [AW-1:0] scrub_addr;
  logic [SW-1:0] starve_cnt;
  logic [DW-1:0] wb_data;
  logic          scrub_want, scrub_gnt, host_win, cancel, advance;

  assign bus.host_gnt   = host_win;
  assign bus.host_rdata = bus.mem_rdata;
  assign scrub_busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Arbitration, next-state selection and the memory port mux.
  always_comb begin
    scrub_want = rst_n && (state == RD || state == WB);
    scrub_gnt  = scrub_want && (!bus.host_req || starve_cnt == STARVE_LIM);
    host_win   = rst_n && bus.host_req && !scrub_gnt;
    // A newer host write to the address under repair makes the write-back stale.
    cancel     = host_win && bus.host_we && (bus.host_addr == scrub_addr) &&
                 (state == CHK || state == WB);
    advance    = 1'b0;
    state_nx   = state;
    case (state)
      IDLE: if (scrub_en && ivl_cnt == IVL_LAST) state_nx = RD;
      RD:   if (scrub_gnt) state_nx = CHK;
      CHK:  if (bus.mem_mismatch && !cancel) state_nx = WB;
            else advance = 1'b1;
      WB:   if (scrub_gnt || cancel) advance = 1'b1;
      default: state_nx = IDLE;
    endcase
    if (advance) state_nx = (!scrub_en || scrub_addr == '1) ? IDLE : RD;

    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (scrub_gnt) begin
      bus.mem_re   = (state == RD);
      bus.mem_we   = (state == WB);
      bus.mem_addr = scrub_addr;
      if (state == WB) bus.mem_wdata = wb_data;
    end else if (host_win) begin
      bus.mem_re   = !bus.host_we;
      bus.mem_we   = bus.host_we;
      bus.mem_addr = bus.host_addr;
      if (bus.host_we) bus.mem_wdata = bus.host_wdata;
    end
  end

  // Sweep bookkeeping, starvation counter, statistics and host read valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ivl_cnt         <= '0;
      scrub_addr      <= '0;
      starve_cnt      <= '0;
      wb_data         <= '0;
      err_count       <= '0;
      sweep_count     <= '0;
      sweep_done      <= 1'b0;
      bus.host_rvalid <= 1'b0;
    end else begin
      sweep_done      <= 1'b0;
      bus.host_rvalid <= host_win && !bus.host_we;

      if (state == IDLE) begin
        if (!scrub_en || ivl_cnt == IVL_LAST) ivl_cnt <= '0;
        else                                  ivl_cnt <= ivl_cnt + 1'b1;
        if (state_nx == RD) scrub_addr <= '0;
      end

      if (scrub_gnt)       starve_cnt <= '0;
      else if (scrub_want) starve_cnt <= starve_cnt + 1'b1;

      if (state == CHK) begin
        wb_data <= bus.mem_rdata;
        if (bus.mem_mismatch && err_count != '1) err_count <= err_count + 1'b1;
      end

      if (advance) begin
        ivl_cnt <= '0;
        if (!scrub_en) begin
          scrub_addr <= '0;
        end else if (scrub_addr == '1) begin
          scrub_addr <= '0;
          sweep_done <= 1'b1;
          if (sweep_count != '1) sweep_count <= sweep_count + 1'b1;
        end else begin
          scrub_addr <= scrub_addr + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tmr_scrub_arbiter.sv
// Bench for tmr_scrub_arbiter: a bench-side memory answers reads (with
// one-shot mismatch injection), a behavioural model is checked every cycle,
// and directed phases pin the timing with literal expectations.
module tb_tmr_scrub_arbiter;
  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int IVL   = 200;
  localparam int SMAX  = 8;
  localparam int CW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          scrub_en;
  logic          scrub_busy, sweep_done;
  logic [CW-1:0] err_count, sweep_count;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc  = 0;

  tmr_scrub_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  tmr_scrub_arbiter #(
    .AW(AW), .DW(DW), .SCRUB_INTERVAL(IVL), .STARVE_MAX(SMAX), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en), .bus(bus),
    .scrub_busy(scrub_busy), .sweep_done(sweep_done),
    .err_count(err_count), .sweep_count(sweep_count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    ncyc++;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- bench memory ----------------
  logic [DW-1:0] mem [DEPTH];
  int            wr_cnt [DEPTH];
  bit            rsp_valid;
  logic [AW-1:0] rsp_addr;
  int            inj_req = 0;
  int            inj_done = 0;
  int            inj_addr = 0;
  logic [DW-1:0] inj_data = '0;

  // Capture port activity of the cycle (reads answered next cycle, writes applied).
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]    = DW'(i * 7 + 3);
      wr_cnt[i] = 0;
    end
    rsp_valid = 1'b0;
    rsp_addr  = '0;
    forever begin
      @(negedge clk);
      rsp_valid = bus.mem_re;
      rsp_addr  = bus.mem_addr;
      if (bus.mem_we) begin
        mem[bus.mem_addr]    = bus.mem_wdata;
        wr_cnt[bus.mem_addr] = wr_cnt[bus.mem_addr] + 1;
      end
    end
  end

  // Drive voted read data one cycle after a read, injecting a mismatch when armed.
  initial begin
    bus.mem_rdata    = '0;
    bus.mem_mismatch = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_mismatch = 1'b0;
      bus.mem_rdata    = '0;
      if (rsp_valid) begin
        if (inj_req != inj_done && int'(rsp_addr) == inj_addr) begin
          bus.mem_rdata    = inj_data;
          bus.mem_mismatch = 1'b1;
          inj_done         = inj_req;
        end else begin
          bus.mem_rdata = mem[rsp_addr];
        end
      end
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  initial begin
    bit            m_sweep, m_rd, m_chk, m_wr, m_rvalid, m_done;
    int            m_idle, m_addr, m_starve, m_err, m_swp;
    logic [DW-1:0] m_wb;
    bit            want, sw, hg, hit, fin, e_re, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    m_sweep = 0; m_rd = 0; m_chk = 0; m_wr = 0; m_rvalid = 0; m_done = 0;
    m_idle = 0; m_addr = 0; m_starve = 0; m_err = 0; m_swp = 0; m_wb = '0;
    forever begin
      @(negedge clk);
      want   = rst_n && (m_rd || m_wr);
      sw     = want && (!bus.host_req || m_starve == SMAX);
      hg     = rst_n && bus.host_req && !sw;
      e_re   = sw ? m_rd : (hg && !bus.host_we);
      e_we   = sw ? m_wr : (hg && bus.host_we);
      e_addr = sw ? AW'(m_addr) : (hg ? bus.host_addr : '0);
      e_wd   = (sw && m_wr) ? m_wb : ((hg && bus.host_we) ? bus.host_wdata : '0);

      check("host_gnt", bus.host_gnt, hg);
      check("mem_re", bus.mem_re, e_re);
      check("mem_we", bus.mem_we, e_we);
      check("mem_addr", bus.mem_addr, e_addr);
      check("mem_wdata", bus.mem_wdata, e_wd);
      check("host_rvalid", bus.host_rvalid, m_rvalid);
      if (m_rvalid) check("host_rdata", bus.host_rdata, bus.mem_rdata);
      check("sweep_done", sweep_done, m_done);
      check("err_count", err_count, m_err);
      check("sweep_count", sweep_count, m_swp);
      check("scrub_busy", scrub_busy, m_sweep);

      if (!rst_n) begin
        m_sweep = 0; m_rd = 0; m_chk = 0; m_wr = 0; m_rvalid = 0; m_done = 0;
        m_idle = 0; m_addr = 0; m_starve = 0; m_err = 0; m_swp = 0; m_wb = '0;
      end else begin
        m_rvalid = hg && !bus.host_we;
        m_done   = 0;
        if (sw)        m_starve = 0;
        else if (want) m_starve++;
        if (!m_sweep) begin
          if (scrub_en) begin
            m_idle++;
            if (m_idle == IVL) begin
              m_sweep = 1; m_rd = 1; m_addr = 0; m_idle = 0;
            end
          end else begin
            m_idle = 0;
          end
        end else if (m_rd) begin
          if (sw) begin
            m_rd = 0; m_chk = 1;
          end
        end else begin
          hit = hg && bus.host_we && (int'(bus.host_addr) == m_addr);
          fin = 0;
          if (m_chk) begin
            m_chk = 0;
            m_wb  = bus.mem_rdata;
            if (bus.mem_mismatch && m_err < (1 << CW) - 1) m_err++;
            if (bus.mem_mismatch && !hit) m_wr = 1;
            else fin = 1;
          end else if (sw || hit) begin
            m_wr = 0; fin = 1;
          end
          if (fin) begin
            if (!scrub_en) begin
              m_sweep = 0; m_addr = 0;
            end else if (m_addr == DEPTH - 1) begin
              m_sweep = 0; m_addr = 0; m_done = 1;
              if (m_swp < (1 << CW) - 1) m_swp++;
            end else begin
              m_addr++; m_rd = 1;
            end
          end
        end
      end
    end
  end

  // Wait (from a negedge) until a read of address a appears, bounded.
  task automatic wait_re(input int a, input int budget, input string nm);
    int k;
    k = 0;
    while (!(bus.mem_re && int'(bus.mem_addr) == a) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(nm, {63'b0, bus.mem_re && int'(bus.mem_addr) == a}, 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int t0, c, first_re, second_re, done_cyc, done_n, steps, nwe, ngnt, nrv;
    logic [9:0] gseq;
    rst_n = 1'b0; scrub_en = 1'b0;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_host_gnt", bus.host_gnt, 0);
    check("reset_mem_re", bus.mem_re, 0);
    check("reset_busy", scrub_busy, 0);

    // Phase 1: idle timing and a clean sweep.
    @(posedge clk); #1;
    rst_n = 1'b1; scrub_en = 1'b1; bus.host_req = 1'b0;
    t0 = ncyc;
    first_re = -1; second_re = -1; done_cyc = -1; done_n = 0;
    for (int k = 0; k < 700 && second_re < 0; k++) begin
      @(negedge clk);
      c = ncyc - t0;
      if (sweep_done) begin done_n++; done_cyc = c; end
      if (bus.mem_re && bus.mem_addr == '0) begin
        if (first_re < 0) first_re = c;
        else if (done_n > 0) second_re = c;
      end
    end
    check("first_scrub_read_cycle", first_re, 200);
    check("sweep_done_cycle", done_cyc, 328);
    check("sweep_done_pulses", done_n, 1);
    check("second_sweep_start_cycle", second_re, 528);
    check("sweep_count_after_sweep", sweep_count, 1);
    check("err_count_after_sweep", err_count, 0);

    // Phase 2: repair of address 5.
    inj_addr = 5; inj_data = 8'h2A; inj_req++;
    wait_re(5, 40, "reach_read_addr5");
    @(negedge clk);
    @(negedge clk);
    check("repair_mem_we", bus.mem_we, 1);
    check("repair_mem_addr", bus.mem_addr, 5);
    check("repair_mem_wdata", bus.mem_wdata, 8'h2A);
    @(negedge clk);
    check("resume_mem_re", bus.mem_re, 1);
    check("resume_mem_addr", bus.mem_addr, 6);
    check("repair_err_count", err_count, 1);

    // Phase 3: host write to the address under repair cancels the write-back.
    inj_addr = 9; inj_data = 8'h11; inj_req++;
    wait_re(9, 40, "reach_read_addr9");
    @(posedge clk); #1;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 6'd9; bus.host_wdata = 8'h77;
    @(negedge clk);
    check("cancel_host_gnt", bus.host_gnt, 1);
    check("cancel_host_wdata", bus.mem_wdata, 8'h77);
    @(posedge clk); #1;
    bus.host_req = 1'b0; bus.host_we = 1'b0;
    steps = 0; nwe = 0;
    do begin
      @(negedge clk);
      steps++;
      if (bus.mem_we) nwe++;
    end while (!bus.mem_re && steps < 8);
    check("cancel_cycles_to_next_read", steps, 1);
    check("cancel_next_addr", bus.mem_addr, 10);
    check("cancel_scrub_writes", nwe, 0);
    check("cancel_addr9_writes", wr_cnt[9], 1);
    check("cancel_addr9_data", mem[9], 8'h77);
    check("cancel_err_count", err_count, 2);

    // Phase 4: starvation guard with back-to-back host reads.
    @(negedge clk);
    @(posedge clk); #1;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 6'd32;
    ngnt = 0; nrv = 0; gseq = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      gseq[k] = bus.host_gnt;
      if (bus.host_gnt) ngnt++;
      if (bus.host_rvalid) nrv++;
      if (k == 8) begin
        check("starve_scrub_re", bus.mem_re, 1);
        check("starve_scrub_addr", bus.mem_addr, 11);
      end
      @(posedge clk); #1;
      bus.host_addr = AW'(33 + k);
    end
    bus.host_req = 1'b0;
    @(negedge clk);
    if (bus.host_rvalid) nrv++;
    check("starve_gnt_pattern", gseq, 10'h2FF);
    check("starve_gnt_count", ngnt, 9);
    check("starve_rvalid_count", nrv, ngnt);

    // Phase 5: disable mid-sweep at address 20.
    wait_re(20, 40, "reach_read_addr20");
    @(posedge clk); #1;
    scrub_en = 1'b0;
    @(negedge clk);
    check("disable_busy_chk", scrub_busy, 1);
    steps = 0; nwe = 0; done_n = 0;
    for (int k = 0; k < 260; k++) begin
      @(negedge clk);
      if (scrub_busy) steps++;
      if (bus.mem_re || bus.mem_we) nwe++;
      if (sweep_done) done_n++;
    end
    check("disable_busy_cycles", steps, 0);
    check("disable_port_use", nwe, 0);
    check("disable_no_done", done_n, 0);
    check("disable_sweep_count", sweep_count, 1);

    // Phase 6: reset during write-back.
    @(posedge clk); #1;
    scrub_en = 1'b1;
    inj_addr = 2; inj_data = 8'h5C; inj_req++;
    @(negedge clk);
    wait_re(2, 260, "reach_read_addr2");
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 6'd3; bus.host_wdata = 8'hEE;
    @(negedge clk);
    check("rst_wb_mem_we", bus.mem_we, 0);
    check("rst_wb_host_gnt", bus.host_gnt, 0);
    check("err_before_reset", err_count, 3);
    @(negedge clk);
    check("post_rst_host_gnt", bus.host_gnt, 0);
    check("post_rst_host_rvalid", bus.host_rvalid, 0);
    check("post_rst_host_rdata", bus.host_rdata, 0);
    check("post_rst_mem_we", bus.mem_we, 0);
    check("post_rst_mem_re", bus.mem_re, 0);
    check("post_rst_mem_addr", bus.mem_addr, 0);
    check("post_rst_mem_wdata", bus.mem_wdata, 0);
    check("post_rst_busy", scrub_busy, 0);
    check("post_rst_sweep_done", sweep_done, 0);
    check("post_rst_err_count", err_count, 0);
    check("post_rst_sweep_count", sweep_count, 0);
    check("post_rst_addr2_writes", wr_cnt[2], 0);
    check("post_rst_addr3_writes", wr_cnt[3], 0);
    @(posedge clk); #1;
    rst_n = 1'b1; bus.host_req = 1'b0; bus.host_we = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tmr_scrub_arbiter.md
Name: tmr_scrub_arbiter

Overview:
Shares the single port of the triplicated (TMR) memory between a host requester and a background scrubber.
- The scrubber periodically sweeps every address with a read.
- When the memory's voter reports a replica mismatch, the scrubber writes the voted word back, which repairs the single upset replica.
- Host traffic has priority. A starvation guard guarantees the scrubber a slot.
- The block sits between the host interface and the TMR memory, inside the top level.

Parameters:
AW, 6, memory address width (depth 2^AW)
DW, 8, memory data width
SCRUB_INTERVAL, 200, idle cycles between the end of one sweep and the start of the next (>=1)
STARVE_MAX, 8, consecutive denied scrubber cycles before the scrubber forcibly wins the port (>=1)
CW, 16, width of the statistics counters

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
scrub_en  in  1  enables periodic sweeps
host_req  in  1  host access request
host_we  in  1  1=write, 0=read
host_addr  in  AW  host address
host_wdata  in  DW  host write data
host_gnt  out  1  host access accepted this cycle (combinational)
host_rvalid  out  1  host read data valid (1 cycle after granted read)
host_rdata  out  DW  voted read data (passthrough of mem_rdata)
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  voted read data, valid 1 cycle after mem_re
mem_mismatch  in  1  replicas disagreed on last read, valid with mem_rdata
scrub_busy  out  1  state != IDLE
sweep_done  out  1  one-cycle pulse on completion of a full sweep
err_count  out  CW  mismatches detected, saturating
sweep_count  out  CW  completed sweeps, saturating

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - State is IDLE; the interval counter, scrub_addr and starve_cnt are 0.
  - All outputs are 0, and host_gnt=0 while in reset.
- IDLE:
  - If scrub_en=1, the interval counter increments every cycle. When it reaches SCRUB_INTERVAL-1, the next state is RD with scrub_addr=0.
  - If scrub_en=0, the interval counter is held at 0.
- RD: the scrubber requests a read of scrub_addr. When granted (mem_re=1, mem_addr=scrub_addr), the next state is CHK.
- CHK: no port use; the host may be granted. The block latches mem_rdata into wb_data.
  - If mem_mismatch=1, err_count increments (saturating).
  - If mem_mismatch=1 and there is no cancel, the next state is WB. Otherwise the scrubber ADVANCEs.
- WB: the scrubber requests a write of wb_data to scrub_addr. When granted (mem_we=1), it ADVANCEs.
- Cancel: a host write granted to scrub_addr while in CHK or WB cancels the pending write-back, because the host data is newer. The scrubber ADVANCEs without writing. err_count still counts the mismatch.
- ADVANCE:
  - If scrub_addr == 2^AW-1: pulse sweep_done, increment sweep_count (saturating), reset the interval counter, and go to IDLE.
  - Otherwise: scrub_addr+1 and go to RD.
  - If scrub_en=0 at ADVANCE: go to IDLE, with no sweep_done, and reset scrub_addr to 0.
- Arbitration each cycle while the scrubber wants the port (state RD or WB):
  - scrub_wins = !host_req || starve_cnt == STARVE_MAX.
  - host_gnt = host_req && !scrub_wins. When the scrubber does not want the port, host_gnt = host_req.
  - starve_cnt increments on each denied scrubber cycle and clears on each scrubber grant.
- Memory outputs: a combinational mux of the port winner. mem_we and mem_re are never both 1, and both are 0 with no winner.
- Host reads: host_rvalid is a register set to (host_gnt && !host_we) and valid the following cycle. host_rdata = mem_rdata.
- Host writes complete in the grant cycle and produce no response.
- scrub_busy is combinational from the state.

Test Plan:
- Idle timing: release reset with scrub_en=1 and no host traffic -> first mem_re with mem_addr=0 at cycle 200 after reset release. The sweep takes 128 cycles (RD/CHK per address). sweep_done pulses once, sweep_count=1, err_count=0, and the next sweep starts 200 cycles later.
- Repair: during a sweep, drive mem_mismatch=1 with mem_rdata=0x2A for the read of addr 5 -> in the following cycle mem_we=1, mem_addr=5, mem_wdata=0x2A. err_count=1 and the sweep continues at addr 6.
- Starvation guard: hold host_req=1 (back-to-back reads) while the scrubber is in RD -> host_gnt=1 for 8 cycles, then host_gnt=0 for one cycle while mem_re=1 for the scrubber, then the host resumes. Host rvalids correspond 1:1 with host grants.
- Cancel: mismatch at addr 9, then a host write of 0x77 to addr 9 granted during CHK -> no scrubber write occurs, mem_wdata for addr 9 is 0x77 only, and err_count increments by 1.
- Control and reset: deassert scrub_en mid-sweep at addr 20 -> the scrubber finishes addr 20, returns to IDLE, and sweep_done stays 0. Assert rst_n=0 during WB -> the next cycle has all outputs 0 and no memory write.
